// File: rtl/min_pool_pkg.sv
// rtl/min_pool_pkg.sv - shared types, constants and compare helper for the min-pooling sequencer
package min_pool_pkg;

  typedef struct packed {
    logic       sign;
    logic [7:0] mag;
  } sm9_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } pool_state_t;

  localparam logic [8:0] SM9_POS_ZERO = 9'h000;
  localparam logic [8:0] SM9_NEG_ZERO = 9'h100;

  // Strict sign-magnitude less-than; -0 sorts below +0.
  function automatic logic sm9_lt(input sm9_t a, input sm9_t b);
    if (a.sign != b.sign) return a.sign;
    if (a.sign)           return a.mag > b.mag;
    return a.mag < b.mag;
  endfunction

endpackage

// File: rtl/min_9bit.sv
// rtl/min_9bit.sv - combinational sign-magnitude minimum of two 9-bit operands
module min_9bit
  import min_pool_pkg::*;
(
  input  logic [8:0] a,
  input  logic [8:0] b,
  output logic [8:0] y
);

  sm9_t sa, sb;
  logic a_lt_b;

  assign sa = sm9_t'(a);
  assign sb = sm9_t'(b);

  always_comb begin
    a_lt_b = 1'b0;
    if (sa.sign != sb.sign)
      a_lt_b = sa.sign;
    else if (sa.sign)
      a_lt_b = sa.mag > sb.mag;
    else
      a_lt_b = sa.mag < sb.mag;
  end

  // Ties take b; equal encodings are interchangeable.
  assign y = a_lt_b ? a : b;

endmodule

// File: rtl/min_pool_seq.sv
// rtl/min_pool_seq.sv - streaming min-pooling sequencer over sign-magnitude operands
// MIN_POOL_ARGMIN_EN adds out_index, the zero-based position of the first minimum.
module min_pool_seq
  import min_pool_pkg::*;
#(
  parameter  int MAX_WIN = 16,
  localparam int CNT_W   = $clog2(MAX_WIN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] cfg_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [8:0]       in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [8:0]       out_data,
`ifdef MIN_POOL_ARGMIN_EN
  output logic [CNT_W-1:0] out_index,
`endif
  output logic [CNT_W-1:0] out_count
);

  pool_state_t      state, state_nxt;
  logic [8:0]       acc, fold;
  logic [CNT_W-1:0] cnt, len, len_clamp, cnt_inc;
  logic             armed;
  logic             fire;

  assign len_clamp = (cfg_len == '0 || cfg_len > CNT_W'(MAX_WIN)) ? CNT_W'(MAX_WIN) : cfg_len;
  assign cnt_inc   = cnt + CNT_W'(1);
  assign fire      = in_valid & in_ready;

  min_9bit u_fold (
    .a (acc),
    .b (in_data),
    .y (fold)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fire) state_nxt = (in_last || len_clamp == CNT_W'(1)) ? HOLD : ACCUM;
      ACCUM:   if (fire && (cnt_inc == len || in_last)) state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // armed keeps in_ready low while reset is held, even though the reset state is IDLE.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE, ACCUM: in_ready  = armed;
      HOLD:        out_valid = 1'b1;
      default:     ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed <= 1'b0;
      acc   <= SM9_POS_ZERO;
      cnt   <= '0;
      len   <= '0;
    end else begin
      armed <= 1'b1;
      if (fire && state == IDLE) begin
        acc <= in_data;
        cnt <= CNT_W'(1);
        len <= len_clamp;
      end else if (fire && state == ACCUM) begin
        acc <= fold;
        cnt <= cnt_inc;
      end
    end
  end

  assign out_data  = acc;
  assign out_count = cnt;

`ifdef MIN_POOL_ARGMIN_EN
  logic [CNT_W-1:0] idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      idx <= '0;
    else if (fire && state == IDLE)
      idx <= '0;
    else if (fire && state == ACCUM && sm9_lt(sm9_t'(in_data), sm9_t'(acc)))
      idx <= cnt;
  end

  assign out_index = idx;
`endif

endmodule

// File: tb/tb_min_pool_seq.sv
// tb/tb_min_pool_seq.sv - scoreboard bench for min_pool_seq
module tb_min_pool_seq;

  localparam int MAX_WIN = 16;
  localparam int CNT_W   = $clog2(MAX_WIN + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic [CNT_W-1:0] cfg_len;
  logic             in_valid, in_ready, in_last;
  logic [8:0]       in_data;
  logic             out_valid, out_ready;
  logic [8:0]       out_data;
  logic [CNT_W-1:0] out_count;
`ifdef MIN_POOL_ARGMIN_EN
  logic [CNT_W-1:0] out_index;
`endif

  typedef struct {
    logic [8:0] d;
    int         c;
    int         ix;
  } exp_t;

  exp_t       sb[$];
  logic [8:0] wb[$];
  int         n_checks = 0;
  int         n_errors = 0;
  bit         rnd = 1'b0;

  always #5 clk = ~clk;

  min_pool_seq #(.MAX_WIN(MAX_WIN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_len   (cfg_len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef MIN_POOL_ARGMIN_EN
    .out_index (out_index),
`endif
    .out_count (out_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Sign-magnitude ordering key: -0 maps just below +0.
  function automatic int key(input logic [8:0] v);
    return v[8] ? -(2 * int'(v[7:0]) + 1) : 2 * int'(v[7:0]);
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_out", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_data", 32'(out_data), 32'(e.d));
        check("out_count", 32'(out_count), 32'(e.c));
`ifdef MIN_POOL_ARGMIN_EN
        check("out_index", 32'(out_index), 32'(e.ix));
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_beat(input logic [8:0] d, input logic last);
    int guard = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && guard < 200) begin
      tick();
      guard++;
    end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_window(input int cfg, input bit last_flag);
    exp_t e;
    int   n = wb.size();
    e.d  = wb[0];
    e.ix = 0;
    e.c  = n;
    for (int i = 1; i < n; i++)
      if (key(wb[i]) < key(e.d)) begin
        e.d  = wb[i];
        e.ix = i;
      end
    sb.push_back(e);
    cfg_len = CNT_W'(cfg);
    for (int i = 0; i < n; i++) begin
      send_beat(wb[i], last_flag && i == n - 1);
      cfg_len = CNT_W'(1);
    end
    check("latency_out_valid", 32'(out_valid), 32'd1);
  endtask

  task automatic drain();
    int guard = 0;
    while (sb.size() != 0 && guard < 300) begin
      if (!rnd) out_ready = 1'b1;
      tick();
      guard++;
    end
    check("drain_left", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    cfg_len   = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    rst_n = 1'b1;
    tick();
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    wb = '{9'h005, 9'h103, 9'h000, 9'h1C8};
    send_window(4, 1'b0);
    drain();

    wb = '{9'h010, 9'h100, 9'h000};
    send_window(8, 1'b1);
    drain();

    out_ready = 1'b0;
    wb = '{9'h007, 9'h007, 9'h009};
    send_window(3, 1'b0);
    in_valid = 1'b1;
    in_data  = 9'h0AA;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_out_data", 32'(out_data), 32'h007);
      check("stall_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    wb = '{9'h0AA};
    send_window(2, 1'b1);
    drain();

    wb.delete();
    for (int i = 0; i < 16; i++) wb.push_back(9'(9'h0FF - i));
    send_window(0, 1'b0);
    wb = '{9'h033};
    send_window(0, 1'b1);
    drain();

    wb = '{9'h1FF};
    send_window(1, 1'b0);
    drain();

    cfg_len = CNT_W'(4);
    send_beat(9'h1FE, 1'b0);
    send_beat(9'h1FD, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
    check("midrst_in_ready_up", 32'(in_ready), 32'd1);
    wb = '{9'h020, 9'h030, 9'h040, 9'h050};
    send_window(4, 1'b0);
    drain();

    rnd = 1'b1;
    for (int w = 0; w < 6; w++) begin
      int cfg, eff, n;
      bit lst;
      cfg = int'($urandom_range(0, 20));
      eff = (cfg == 0 || cfg > MAX_WIN) ? MAX_WIN : cfg;
      n   = int'($urandom_range(1, eff));
      lst = (n < eff) ? 1'b1 : 1'($urandom_range(0, 1));
      wb.delete();
      for (int i = 0; i < n; i++) wb.push_back(9'($urandom_range(0, 511)));
      send_window(cfg, lst);
    end
    drain();
    rnd = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
